// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU.
// Sequences fetch/decode/execute/memory/writeback, drives datapath selects,
// register/memory strobes and the three PC write requests. Memory accesses
// in FETCH, MEMRD and MEMWR are stretched until MemReady is high.
`timescale 1ns/1ps

module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteIfZero,
    output logic       PCWriteIfNonZero,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_BNE    = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state, state_next;

    assign State = state;

    // State register; reset aborts any instruction in flight, including memory waits.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    // Next-state and Moore/Mealy output decode; everything is forced to 0 while in reset.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next       = S_FETCH;
        PCWrite          = 1'b0;
        PCWriteIfZero    = 1'b0;
        PCWriteIfNonZero = 1'b0;
        IorD             = 1'b0;
        MemRead          = 1'b0;
        MemWrite         = 1'b0;
        IRWrite          = 1'b0;
        RegDst           = 1'b0;
        MemtoReg         = 1'b0;
        RegWrite         = 1'b0;
        ALUSrcA          = 1'b0;
        ALUSrcB          = 2'b00;
        ALUOp            = 2'b00;
        PCSource         = 2'b00;
        IllegalOp        = 1'b0;

        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    MemRead    = 1'b1;
                    ALUSrcB    = 2'b01;
                    IRWrite    = MemReady;
                    PCWrite    = MemReady;
                    state_next = MemReady ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    case (Op)
                        OP_RTYPE:     state_next = S_EXEC;
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_BEQ:       state_next = S_BEQ;
                        OP_BNE:       state_next = S_BNE;
                        OP_J:         state_next = S_JUMP;
                        OP_ADDI:      state_next = S_ADDIEX;
                        default: begin
                            IllegalOp  = 1'b1;
                            state_next = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    // Only lw/sw reach here; anything other than sw is treated as a load.
                    state_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    MemRead    = 1'b1;
                    IorD       = 1'b1;
                    state_next = MemReady ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    state_next = MemReady ? S_FETCH : S_MEMWR;
                end
                S_EXEC: begin
                    ALUSrcA    = 1'b1;
                    ALUOp      = 2'b10;
                    state_next = S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA       = 1'b1;
                    ALUOp         = 2'b01;
                    PCSource      = 2'b01;
                    PCWriteIfZero = 1'b1;
                end
                S_BNE: begin
                    ALUSrcA          = 1'b1;
                    ALUOp            = 2'b01;
                    PCSource         = 2'b01;
                    PCWriteIfNonZero = 1'b1;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_ADDIEX: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    state_next = S_ADDIWB;
                end
                S_ADDIWB: begin
                    RegWrite = 1'b1;
                end
                // Encodings 13-15 are unreachable: all outputs 0, recover to FETCH.
                default: state_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM of the multicycle CPU. It decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback. It drives the datapath mux selects, the register and memory strobes, and the three PC write requests (PCWrite, PCWriteIfZero, PCWriteIfNonZero) that the PC write-enable logic combines with the ALU zero flag. Memory accesses are stretched by a MemReady handshake.

## Interface
- No parameters. State encoding is fixed, listed below.
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- Op  in  6  opcode from the instruction register (IR[31:26])
- MemReady  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteIfZero  out  1  PC load if zero=1 (beq)
- PCWriteIfNonZero  out  1  PC load if zero=0 (bne)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register select: 0 = rt, 1 = rd
- MemtoReg  out  1  write data select: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- ALUOp  out  2  ALU op class: 00 = add, 01 = subtract, 10 = funct-decoded
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- IllegalOp  out  1  one-cycle flag: undefined opcode seen in DECODE
- State  out  4  current state, for debug

## Operation
- Outputs are decoded from State. FETCH, MEMRD and MEMWR also depend on MemReady.
- Every output not listed for a state is 0.
- FETCH (0)
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=MemReady, PCWrite=MemReady.
  - Next state: DECODE if MemReady, otherwise FETCH.
- DECODE (1)
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by Op:
    - 000000 (R-type) → EXEC
    - 100011 (lw) and 101011 (sw) → MEMADR
    - 000100 (beq) → BEQ
    - 000101 (bne) → BNE
    - 000010 (j) → JUMP
    - 001000 (addi) → ADDIEX
    - any other opcode → FETCH, with IllegalOp=1 in this cycle
- MEMADR (2)
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: MEMRD for lw, MEMWR for sw. Op is still held in IR.
- MEMRD (3)
  - Outputs: MemRead=1, IorD=1.
  - Next state: MEMWB if MemReady, otherwise MEMRD.
- MEMWB (4)
  - Outputs: RegWrite=1, MemtoReg=1, RegDst=0.
  - Next state: FETCH.
- MEMWR (5)
  - Outputs: MemWrite=1, IorD=1.
  - Next state: FETCH if MemReady, otherwise MEMWR.
- EXEC (6)
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next state: ALUWB.
- ALUWB (7)
  - Outputs: RegWrite=1, RegDst=1, MemtoReg=0.
  - Next state: FETCH.
- BEQ (8)
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteIfZero=1.
  - Next state: FETCH.
- BNE (9)
  - Outputs: same as BEQ, except PCWriteIfNonZero=1 replaces PCWriteIfZero.
  - Next state: FETCH.
- JUMP (10)
  - Outputs: PCWrite=1, PCSource=10.
  - Next state: FETCH.
- ADDIEX (11)
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: ADDIWB.
- ADDIWB (12)
  - Outputs: RegWrite=1, RegDst=0, MemtoReg=0.
  - Next state: FETCH.
- Encodings 13–15 are unreachable. If entered, next state is FETCH and all outputs are 0.
- Invariants that hold in every state:
  - At most one of PCWrite, PCWriteIfZero and PCWriteIfNonZero is 1.
  - MemRead and MemWrite are never both 1.

## Timing
- Reset
  - While rst_n=0: State=0 and all outputs are forced to 0, including the FETCH strobes.
  - The first rising edge after rst_n rises is the first FETCH cycle.
  - Reset asserted mid-instruction aborts it immediately, including during a memory wait. No partial writeback occurs after reset.
- Instruction latency with MemReady held at 1:
  - R-type and addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq, bne and j: 3 cycles
  - illegal opcode: 2 cycles
- Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- While waiting on MemReady, all outputs stay stable and IRWrite/PCWrite remain 0.
- Op is sampled only in DECODE and MEMADR. Op changes in any other cycle are ignored.

## Test plan
- Reset: drive rst_n=0 mid-MEMRD → State=0 and all outputs 0 at once. After release with MemReady=1, MemRead=1, IRWrite=1, PCWrite=1 in the first cycle.
- R-type then addi, MemReady=1: State sequence 0,1,6,7,0,1,11,12. RegDst=1 only in state 7; RegWrite=1 in states 7 and 12.
- lw with MemReady low for 3 cycles in MEMRD: sequence 0,1,2,3,3,3,3,4,0. MemtoReg=1 only in state 4.
- sw: sequence 0,1,2,5,0. MemWrite=1 for exactly one cycle; RegWrite stays 0 throughout.
- beq, bne, j: beq raises PCWriteIfZero only (PCSource=01); bne raises PCWriteIfNonZero only; j raises PCWrite with PCSource=10. Check the PC-strobe one-hot invariant every cycle.
- Op=111111: IllegalOp=1 for the single DECODE cycle, then the FSM returns to FETCH. No RegWrite, MemWrite or PC strobe occurs in that instruction after its FETCH cycle.
